// File: rtl/conv_win_buf.sv
// conv_win_buf: streaming KxK window generator over a raster-order pixel stream.
//
// Pixels arrive in raster order qualified by in_valid. K circular line-buffer
// rows hold the most recent image rows; a KxK shift register holds the
// columns of the current window. A window is emitted one cycle after the
// accepted pixel that completes it, at every STRIDE step in both axes.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       in_data carries a pixel this cycle
//   in_sof         (only with CONV_WIN_BUF_SOF_EN) force this pixel to (0,0)
//   in_data        pixel, raster order
//   win_out        window; slot i*K+j is row i, column j; slot 0 is top-left
//   out_valid      win_out valid for one cycle
//   out_last       with out_valid: last window of the frame
//   out_row/col    output-map coordinates of the window
//
// Optional feature macro: CONV_WIN_BUF_SOF_EN (adds in_sof).
module conv_win_buf #(
    parameter int DATA_BITS = 32,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int K         = 3,
    parameter int STRIDE    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
`ifdef CONV_WIN_BUF_SOF_EN
    input  logic                      in_sof,
`endif
    input  logic [DATA_BITS-1:0]      in_data,
    output logic [K*K*DATA_BITS-1:0]  win_out,
    output logic                      out_valid,
    output logic                      out_last,
    output logic [$clog2(IMG_H)-1:0]  out_row,
    output logic [$clog2(IMG_W)-1:0]  out_col
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int PTR_W = $clog2(K);
    localparam int PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned KU = K;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [COL_W-1:0] OCOL_LAST = COL_W'((IMG_W - K) / STRIDE);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
    localparam logic [ROW_W-1:0] OROW_LAST = ROW_W'((IMG_H - K) / STRIDE);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(STRIDE - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(K - 1);

    logic [COL_W-1:0] col, cur_col, ocol, cur_ocol;
    logic [ROW_W-1:0] row, cur_row, orow, cur_orow;
    logic [PH_W-1:0]  col_ph, cur_col_ph, row_ph, cur_row_ph;
    logic [PTR_W-1:0] row_ptr, cur_ptr;

    logic [DATA_BITS-1:0] lb      [K][IMG_W];
    logic [DATA_BITS-1:0] sr      [K][K];
    logic [DATA_BITS-1:0] win_nxt [K][K];
    logic [PTR_W-1:0]     rd_ptr  [K-1];
    logic [K*K*DATA_BITS-1:0] win_flat;
    logic eol, eof, emit;
    int unsigned rd_idx;

    // Position of the pixel presented this cycle; a start-of-frame marker
    // overrides the stored counters so the pixel is handled as (0,0).
    always_comb begin
        cur_col    = col;
        cur_row    = row;
        cur_ocol   = ocol;
        cur_orow   = orow;
        cur_col_ph = col_ph;
        cur_row_ph = row_ph;
        cur_ptr    = row_ptr;
`ifdef CONV_WIN_BUF_SOF_EN
        if (in_valid && in_sof) begin
            cur_col    = '0;
            cur_row    = '0;
            cur_ocol   = '0;
            cur_orow   = '0;
            cur_col_ph = '0;
            cur_row_ph = '0;
            cur_ptr    = '0;
        end
`endif
        eol  = (cur_col == COL_LAST);
        eof  = eol && (cur_row == ROW_LAST);
        emit = in_valid
            && (cur_col >= COL_FIRST) && (cur_col_ph == '0)
            && (cur_row >= ROW_FIRST) && (cur_row_ph == '0);
    end

    // Stored rows in age order: the oldest sits just after the row being written.
    always_comb begin
        rd_idx = 0;
        for (int unsigned i = 0; i < KU - 1; i++) begin
            rd_idx    = cur_ptr + 1 + i;
            rd_ptr[i] = PTR_W'((rd_idx >= KU) ? rd_idx - KU : rd_idx);
        end
    end

    // Next window: shift left one column, new right column from the line
    // buffer plus the incoming pixel at the bottom-right.
    always_comb begin
        for (int unsigned i = 0; i < KU; i++)
            for (int unsigned j = 0; j < KU - 1; j++)
                win_nxt[i][j] = sr[i][j+1];
        for (int unsigned i = 0; i < KU - 1; i++)
            win_nxt[i][K-1] = lb[rd_ptr[i]][cur_col];
        win_nxt[K-1][K-1] = in_data;
    end

    always_comb begin
        win_flat = '0;
        for (int unsigned i = 0; i < KU; i++)
            for (int unsigned j = 0; j < KU; j++)
                win_flat[(i*KU+j)*DATA_BITS +: DATA_BITS] = win_nxt[i][j];
    end

    // Line-buffer RAM and window shift register carry no reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb[cur_ptr][cur_col] <= in_data;
            sr <= win_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            ocol      <= '0;
            orow      <= '0;
            col_ph    <= '0;
            row_ph    <= '0;
            row_ptr   <= '0;
            win_out   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            out_valid <= emit;
            out_last  <= emit && (cur_orow == OROW_LAST) && (cur_ocol == OCOL_LAST);
            if (emit) begin
                win_out <= win_flat;
                out_row <= cur_orow;
                out_col <= cur_ocol;
            end
            if (in_valid) begin
                col     <= cur_col;
                row     <= cur_row;
                ocol    <= cur_ocol;
                orow    <= cur_orow;
                col_ph  <= cur_col_ph;
                row_ph  <= cur_row_ph;
                row_ptr <= cur_ptr;
                if (eol) begin
                    col     <= '0;
                    col_ph  <= '0;
                    ocol    <= '0;
                    row_ptr <= (cur_ptr == PTR_LAST) ? '0 : cur_ptr + PTR_W'(1);
                    if (eof) begin
                        row    <= '0;
                        row_ph <= '0;
                        orow   <= '0;
                    end else begin
                        row <= cur_row + ROW_W'(1);
                        if (cur_row >= ROW_FIRST) begin
                            if (cur_row_ph == PH_LAST) begin
                                row_ph <= '0;
                                orow   <= cur_orow + ROW_W'(1);
                            end else begin
                                row_ph <= cur_row_ph + PH_W'(1);
                            end
                        end
                    end
                end else begin
                    col <= cur_col + COL_W'(1);
                    if (cur_col >= COL_FIRST) begin
                        if (cur_col_ph == PH_LAST) begin
                            col_ph <= '0;
                            ocol   <= cur_ocol + COL_W'(1);
                        end else begin
                            col_ph <= cur_col_ph + PH_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_win_buf.sv
// Bench for conv_win_buf: three instances (K=3 stride 1, K=3 stride 2,
// K=5 on a 10x6 frame) driven one at a time with pixel value = base + raster
// index. Expected windows are computed from the pixel position and pushed to
// a scoreboard when the pixel is driven, then popped when the output appears.
module tb_conv_win_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vin, sofin;
    logic [31:0] din;
    int          sel;

    logic va, vb, vc;
    logic sa, sb_s, sc;
    assign va   = vin && (sel == 0);
    assign vb   = vin && (sel == 1);
    assign vc   = vin && (sel == 2);
    assign sa   = sofin && (sel == 0);
    assign sb_s = sofin && (sel == 1);
    assign sc   = sofin && (sel == 2);

    logic [287:0] win_a, win_b;
    logic [799:0] win_c;
    logic         valid_a, valid_b, valid_c, last_a, last_b, last_c;
    logic [4:0]   row_a, col_a, row_b, col_b;
    logic [2:0]   row_c;
    logic [3:0]   col_c;

    conv_win_buf dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(va),
`ifdef CONV_WIN_BUF_SOF_EN
        .in_sof(sa),
`endif
        .in_data(din), .win_out(win_a), .out_valid(valid_a), .out_last(last_a),
        .out_row(row_a), .out_col(col_a)
    );

    conv_win_buf #(.STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vb),
`ifdef CONV_WIN_BUF_SOF_EN
        .in_sof(sb_s),
`endif
        .in_data(din), .win_out(win_b), .out_valid(valid_b), .out_last(last_b),
        .out_row(row_b), .out_col(col_b)
    );

    conv_win_buf #(.K(5), .IMG_W(10), .IMG_H(6), .STRIDE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vc),
`ifdef CONV_WIN_BUF_SOF_EN
        .in_sof(sc),
`endif
        .in_data(din), .win_out(win_c), .out_valid(valid_c), .out_last(last_c),
        .out_row(row_c), .out_col(col_c)
    );

    always #5 clk = ~clk;

    logic [799:0] o_win;
    logic         o_valid, o_last;
    int           o_row, o_col;

    always_comb begin
        o_win = '0; o_valid = 1'b0; o_last = 1'b0; o_row = 0; o_col = 0;
        case (sel)
            0: begin o_win[287:0] = win_a; o_valid = valid_a; o_last = last_a;
                     o_row = int'(row_a); o_col = int'(col_a); end
            1: begin o_win[287:0] = win_b; o_valid = valid_b; o_last = last_b;
                     o_row = int'(row_b); o_col = int'(col_b); end
            default: begin o_win = win_c; o_valid = valid_c; o_last = last_c;
                     o_row = int'(row_c); o_col = int'(col_c); end
        endcase
    end

    typedef struct {
        logic [799:0] win;
        int           row;
        int           col;
        bit           last;
    } exp_t;

    exp_t         sb[$];
    logic [799:0] last_exp [3];
    int tests = 0, failed = 0;
    int mr = 0, mc = 0;
    int cw = 28, ch = 28, ck = 3, cs = 1;
    int win_cnt = 0, last_cnt = 0;

    task automatic use_dut(input int s);
        sel = s;
        mr = 0; mc = 0;
        case (s)
            0: begin cw = 28; ch = 28; ck = 3; cs = 1; end
            1: begin cw = 28; ch = 28; ck = 3; cs = 2; end
            default: begin cw = 10; ch = 6; ck = 5; cs = 1; end
        endcase
        win_cnt = 0; last_cnt = 0;
    endtask

    // One clock: drive a pixel (or a gap), queue the window it completes,
    // then check the registered output one cycle later.
    task automatic step(input bit v, input bit sof, input int base);
        exp_t e;
        if (v && sof) begin mr = 0; mc = 0; end
        din = base + mr * cw + mc;
        vin = v; sofin = sof;
        if (v) begin
            if (mr >= ck-1 && mc >= ck-1 && (mr-ck+1) % cs == 0 && (mc-ck+1) % cs == 0) begin
                e.row  = (mr-ck+1) / cs;
                e.col  = (mc-ck+1) / cs;
                e.last = (e.row == (ch-ck)/cs) && (e.col == (cw-ck)/cs);
                e.win  = '0;
                for (int i = 0; i < ck; i++)
                    for (int j = 0; j < ck; j++)
                        e.win[(i*ck+j)*32 +: 32] = base + (mr-ck+1+i)*cw + (mc-ck+1+j);
                sb.push_back(e);
            end
            mc++;
            if (mc == cw) begin
                mc = 0; mr++;
                if (mr == ch) mr = 0;
            end
        end
        @(posedge clk); #1;
        vin = 1'b0; sofin = 1'b0;
        if (o_valid) win_cnt++;
        if (o_valid && o_last) last_cnt++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            last_exp[sel] = e.win;
            tests++;
            if (o_valid !== 1'b1 || o_win !== e.win || o_row != e.row ||
                o_col != e.col || o_last !== e.last) begin
                failed++;
                $display("FAIL window dut%0d: got valid=%b last=%b row=%0d col=%0d slot0=%0d slotN=%0d, expected valid=1 last=%b row=%0d col=%0d slot0=%0d slotN=%0d",
                         sel, o_valid, o_last, o_row, o_col, o_win[31:0], o_win[(ck*ck-1)*32 +: 32],
                         e.last, e.row, e.col, e.win[31:0], e.win[(ck*ck-1)*32 +: 32]);
            end
        end else begin
            tests++;
            if (o_valid !== 1'b0 || o_win !== last_exp[sel]) begin
                failed++;
                $display("FAIL idle dut%0d: got valid=%b slot0=%0d, expected valid=0 slot0=%0d (held)",
                         sel, o_valid, o_win[31:0], last_exp[sel][31:0]);
            end
        end
    endtask

    task automatic check_counts(input string name, input int exp_w, input int exp_l);
        tests++;
        if (win_cnt != exp_w || last_cnt != exp_l) begin
            failed++;
            $display("FAIL %s counts: got windows=%0d lasts=%0d, expected windows=%0d lasts=%0d",
                     name, win_cnt, last_cnt, exp_w, exp_l);
        end
    endtask

    task automatic reset_pulse();
        vin = 1'b0; sofin = 1'b0;
        rst_n = 1'b0;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            tests++;
            if (o_valid !== 1'b0 || o_last !== 1'b0 || o_row != 0 || o_col != 0 || o_win !== '0) begin
                failed++;
                $display("FAIL reset dut%0d: got valid=%b last=%b row=%0d col=%0d slot0=%0d, expected all zero",
                         s, o_valid, o_last, o_row, o_col, o_win[31:0]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        for (int s = 0; s < 3; s++) last_exp[s] = '0;
    endtask

    task automatic test_reset();
        reset_pulse();
    endtask

    task automatic test_continuous();
        use_dut(0);
        for (int p = 0; p < 784; p++) step(1'b1, 1'b0, 0);
        check_counts("continuous", 676, 1);
    endtask

    task automatic test_gaps();
        use_dut(0);
        for (int p = 0; p < 784; p++) begin
            while ($urandom_range(0, 1) == 1) step(1'b0, 1'b0, 0);
            step(1'b1, 1'b0, 0);
        end
        check_counts("gaps", 676, 1);
    endtask

    task automatic test_back_to_back();
        use_dut(0);
        for (int f = 0; f < 2; f++)
            for (int p = 0; p < 784; p++) step(1'b1, 1'b0, f * 1000);
        check_counts("back_to_back", 1352, 2);
    endtask

    task automatic test_reset_mid_frame();
        use_dut(0);
        for (int p = 0; p <= 300; p++) step(1'b1, 1'b0, 0);
        reset_pulse();
        use_dut(0);
        for (int p = 0; p < 784; p++) step(1'b1, 1'b0, 0);
        check_counts("reset_mid_frame", 676, 1);
    endtask

    task automatic test_stride2();
        use_dut(1);
        for (int p = 0; p < 784; p++) step(1'b1, 1'b0, 0);
        check_counts("stride2", 169, 1);
    endtask

    task automatic test_k5();
        use_dut(2);
        for (int p = 0; p < 60; p++) step(1'b1, 1'b0, 0);
        check_counts("k5", 12, 1);
    endtask

`ifdef CONV_WIN_BUF_SOF_EN
    task automatic test_sof();
        use_dut(0);
        for (int p = 0; p <= 300; p++) step(1'b1, 1'b0, 0);
        win_cnt = 0; last_cnt = 0;
        for (int p = 0; p < 784; p++) step(1'b1, p == 0, 0);
        check_counts("sof", 676, 1);
        win_cnt = 0; last_cnt = 0;
        for (int p = 0; p < 784; p++) step(1'b1, p == 0, 2000);
        check_counts("sof_natural", 676, 1);
    endtask
`endif

    initial begin
        vin = 1'b0; sofin = 1'b0; din = '0; sel = 0; rst_n = 1'b1;
        for (int s = 0; s < 3; s++) last_exp[s] = '0;
        #1;
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        test_stride2();
        test_k5();
`ifdef CONV_WIN_BUF_SOF_EN
        test_sof();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
